// File: rtl/nkmm_dbus_responder_pkg.sv
// Shared constants for the nkmm data-bus responder: bus widths, peripheral
// register offsets and STATUS bit layout.
package nkmm_dbus_responder_pkg;

  localparam int ADDR_WIDTH  = 16;
  localparam int ACCUM_WIDTH = 24;

  typedef enum logic [2:0] {
    DBUS_TXDATA  = 3'd0,
    DBUS_STATUS  = 3'd1,
    DBUS_RXDATA  = 3'd2,
    DBUS_RXACK   = 3'd3,
    DBUS_CYCLE   = 3'd4,
    DBUS_SCRATCH = 3'd5,
    DBUS_RSVD6   = 3'd6,
    DBUS_RSVD7   = 3'd7
  } dbus_reg_e;

  localparam int STATUS_TX_EMPTY     = 0;
  localparam int STATUS_TX_FULL      = 1;
  localparam int STATUS_TX_OVERFLOW  = 2;
  localparam int STATUS_RX_FULL      = 3;
  localparam int STATUS_TX_COUNT_LSB = 4;
  localparam int STATUS_TX_COUNT_W   = 4;

  function automatic logic [ACCUM_WIDTH-1:0] pack_status(
    input logic       tx_empty,
    input logic       tx_full,
    input logic       tx_overflow,
    input logic       rx_full,
    input logic [3:0] tx_count
  );
    logic [ACCUM_WIDTH-1:0] s;
    s = '0;
    s[STATUS_TX_EMPTY]    = tx_empty;
    s[STATUS_TX_FULL]     = tx_full;
    s[STATUS_TX_OVERFLOW] = tx_overflow;
    s[STATUS_RX_FULL]     = rx_full;
    s[STATUS_TX_COUNT_LSB +: STATUS_TX_COUNT_W] = tx_count;
    return s;
  endfunction

endpackage

// File: rtl/nkmm_fifo.sv
// Small synchronous FIFO with head look-ahead; a push is accepted while full
// only when a pop happens in the same cycle.
module nkmm_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // An empty FIFO presents zero rather than a stale slot.
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only pointers and count are, which is enough to discard contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nkmm_dbus_responder.sv
// Responder for the nkmm CPU data bus: data RAM in the lower half of the
// address space, TX/RX stream, cycle counter and scratch in the upper half.
module nkmm_dbus_responder
  import nkmm_dbus_responder_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int TX_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [ACCUM_WIDTH-1:0] data_i,
  input  logic                   we_i,
  output logic [ACCUM_WIDTH-1:0] data_o,
  output logic [ACCUM_WIDTH-1:0] tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  input  logic [ACCUM_WIDTH-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o
);

  localparam int TXCW = $clog2(TX_DEPTH + 1);

  logic                   sel_periph;
  dbus_reg_e              reg_sel;
  logic [RAM_AW-1:0]      ram_idx;
  logic                   ram_we;
  logic                   periph_we;

  logic                   tx_push;
  logic                   tx_pop;
  logic                   tx_full;
  logic                   tx_empty;
  logic [TXCW-1:0]        tx_count;
  logic [3:0]             tx_count_ext;
  logic                   tx_overflow;

  logic                   rx_full;
  logic                   rx_capture;
  logic [ACCUM_WIDTH-1:0] rx_hold;

  logic [ACCUM_WIDTH-1:0] cycle_cnt;
  logic [ACCUM_WIDTH-1:0] scratch;
  logic [ACCUM_WIDTH-1:0] periph_rdata;

  logic [ACCUM_WIDTH-1:0] ram [2**RAM_AW];

  // Address bits between the RAM index and the region bit simply alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i;

  assign sel_periph = addr_i[ADDR_WIDTH-1];
  assign reg_sel    = dbus_reg_e'(addr_i[2:0]);
  assign ram_idx    = addr_i[RAM_AW-1:0];
  assign ram_we     = we_i && !sel_periph;
  assign periph_we  = we_i && sel_periph;

  assign tx_push    = periph_we && (reg_sel == DBUS_TXDATA);
  assign tx_valid_o = !tx_empty;
  assign tx_pop     = tx_valid_o && tx_ready_i;

  assign rx_ready_o = rst && !rx_full;
  assign rx_capture = rx_valid_i && rx_ready_o;

  nkmm_fifo #(
    .WIDTH (ACCUM_WIDTH),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (data_i),
    .head  (tx_data_o),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_count_ext = 4'(tx_count);

  // NOTE: every branch of the read mux is covered by the default first, so no latch is inferred.
  always_comb begin
    periph_rdata = '0;
    case (reg_sel)
      DBUS_STATUS:  periph_rdata = pack_status(tx_empty, tx_full, tx_overflow,
                                               rx_full, tx_count_ext);
      DBUS_RXDATA:  periph_rdata = rx_hold;
      DBUS_CYCLE:   periph_rdata = cycle_cnt;
      DBUS_SCRATCH: periph_rdata = scratch;
      default:      periph_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= data_i;
  end

  // Single read register: the old RAM word and pre-write peripheral state.
  always_ff @(posedge clk) begin
    if (!rst) data_o <= '0;
    else      data_o <= sel_periph ? periph_rdata : ram[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_overflow <= 1'b0;
      rx_full     <= 1'b0;
      rx_hold     <= '0;
      cycle_cnt   <= '0;
      scratch     <= '0;
    end else begin
      if (periph_we && reg_sel == DBUS_STATUS)
        tx_overflow <= 1'b0;
      else if (tx_push && tx_full && !tx_pop)
        tx_overflow <= 1'b1;

      if (rx_capture) begin
        rx_full <= 1'b1;
        rx_hold <= rx_data_i;
      end else if (periph_we && reg_sel == DBUS_RXACK) begin
        rx_full <= 1'b0;
      end

      if (periph_we && reg_sel == DBUS_CYCLE) cycle_cnt <= data_i;
      else                                    cycle_cnt <= cycle_cnt + ACCUM_WIDTH'(1);

      if (periph_we && reg_sel == DBUS_SCRATCH) scratch <= data_i;
    end
  end

endmodule
